fifo_stream_reader: RTL and testbench

- Read-side companion to async_fifo; lives entirely in the rd_clk domain.
- Drives the FIFO read port (read_en, fifo_empty, data_out, with 1-cycle read latency) and re-presents the words as a valid/ready stream through a small skid buffer.
- Runs at full throughput, and m_ready has no combinational path to read_en.
- Includes an optional incrementing-sequence checker, used for bring-up and burst tests.

---
 rtl/fifo_stream_reader.sv | 123 ++++++++++++
 tb/tb_fifo_stream_reader.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side companion to async_fifo in the rd_clk domain.
// Issues FIFO reads, catches the 1-cycle-latency data in a small skid buffer
// and re-presents it as a valid/ready stream, with an optional
// incrementing-sequence checker for bring-up and burst tests.
module fifo_stream_reader #(
  parameter int unsigned DATA_LEN    = 16,
  parameter int unsigned BUF_DEPTH   = 4,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   rd_clk,
  input  logic                   reset,
  input  logic                   fifo_empty,
  input  logic [DATA_LEN-1:0]    fifo_data,
  output logic                   read_en,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_LEN-1:0]    m_data,
  input  logic                   seq_check_en,
  output logic                   seq_error,
  output logic [COUNT_WIDTH-1:0] err_index,
  output logic [COUNT_WIDTH-1:0] word_count
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    CHECK = 2'd2
  } seq_state_t;

  logic [DATA_LEN-1:0] buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]    head_ptr;
  logic [PTR_W-1:0]    tail_ptr;
  logic [CNT_W-1:0]    buf_count;
  logic                inflight;
  logic [OCC_W-1:0]    occupancy;
  logic                push;
  logic                pop;
  seq_state_t          seq_state;
  logic [DATA_LEN-1:0] expected;

  // Reads are throttled on registered occupancy only, so m_ready never reaches read_en.
  assign occupancy = OCC_W'(buf_count) + OCC_W'(inflight);
  assign read_en   = !reset && !fifo_empty && (occupancy < OCC_W'(BUF_DEPTH));

  // Returned FIFO word lands in the buffer the cycle after its read; stream pops on handshake.
  assign push    = inflight;
  assign m_valid = (buf_count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? buf_mem[head_ptr] : '0;

  // Skid buffer storage; occupancy gating guarantees a free slot for every push.
  always_ff @(posedge rd_clk) begin
    if (push) begin
      buf_mem[tail_ptr] <= fifo_data;
    end
  end

  // Pointers, occupancy, in-flight flag and accepted-word counter.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      head_ptr   <= '0;
      tail_ptr   <= '0;
      buf_count  <= '0;
      inflight   <= 1'b0;
      word_count <= '0;
    end else begin
      inflight <= read_en;
      if (push) begin
        tail_ptr <= tail_ptr + PTR_W'(1);
      end
      if (pop) begin
        head_ptr   <= head_ptr + PTR_W'(1);
        word_count <= word_count + COUNT_WIDTH'(1);
      end
      case ({push, pop})
        2'b10:   buf_count <= buf_count + CNT_W'(1);
        2'b01:   buf_count <= buf_count - CNT_W'(1);
        default: buf_count <= buf_count;
      endcase
    end
  end

  // Sequence checker: sync on the first accepted word, then flag the first break in +1 order.
  always_ff @(posedge rd_clk) begin
    if (reset) begin
      seq_state <= IDLE;
      expected  <= '0;
      seq_error <= 1'b0;
      err_index <= '0;
    end else if (!seq_check_en) begin
      seq_state <= IDLE;
    end else begin
      case (seq_state)
        IDLE: begin
          seq_state <= SYNC;
        end
        SYNC: begin
          if (pop) begin
            expected  <= m_data + DATA_LEN'(1);
            seq_state <= CHECK;
          end
        end
        CHECK: begin
          if (pop) begin
            if ((m_data != expected) && !seq_error) begin
              seq_error <= 1'b1;
              err_index <= word_count;
            end
            expected <= m_data + DATA_LEN'(1);
          end
        end
        default: begin
          seq_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-like FIFO model feeds the DUT and a
// stream-level reference (FIFO pop order, loss at reset, +1 sequence rule)
// checks every accepted word, counter and checker flag.
module tb_fifo_stream_reader;

  localparam int unsigned DATA_LEN    = 16;
  localparam int unsigned BUF_DEPTH   = 4;
  localparam int unsigned COUNT_WIDTH = 32;
  localparam int          FIFO_SIZE   = 4096;

  logic                   rd_clk = 1'b0;
  logic                   reset;
  logic                   fifo_empty;
  logic [DATA_LEN-1:0]    fifo_data;
  logic                   read_en;
  logic                   m_valid;
  logic                   m_ready;
  logic [DATA_LEN-1:0]    m_data;
  logic                   seq_check_en;
  logic                   seq_error;
  logic [COUNT_WIDTH-1:0] err_index;
  logic [COUNT_WIDTH-1:0] word_count;

  fifo_stream_reader #(
    .DATA_LEN   (DATA_LEN),
    .BUF_DEPTH  (BUF_DEPTH),
    .COUNT_WIDTH(COUNT_WIDTH)
  ) dut (
    .rd_clk      (rd_clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .read_en     (read_en),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .seq_check_en(seq_check_en),
    .seq_error   (seq_error),
    .err_index   (err_index),
    .word_count  (word_count)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: words pushed by the tests, popped on read_en with 1-cycle latency.
  logic [DATA_LEN-1:0] fifo_mem [FIFO_SIZE];
  int pushed_cnt = 0;
  int popped_cnt = 0;
  assign fifo_empty = (pushed_cnt == popped_cnt);

  always @(posedge rd_clk) begin
    if (read_en && (pushed_cnt != popped_cnt)) begin
      fifo_data  <= fifo_mem[12'(popped_cnt)];
      popped_cnt <= popped_cnt + 1;
    end else begin
      fifo_data <= 16'($urandom);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int                     exp_idx = 0;
  logic [COUNT_WIDTH-1:0] m_wc = '0;
  bit                     m_on = 0, m_have_prev = 0, m_err = 0;
  logic [DATA_LEN-1:0]    m_prev = '0;
  logic [COUNT_WIDTH-1:0] m_eidx = '0;
  bit                     held = 0;
  logic [DATA_LEN-1:0]    held_data = '0;
  bit                     acc, rd;
  logic [DATA_LEN-1:0]    acc_data;

  task automatic push_word(input logic [DATA_LEN-1:0] v);
    fifo_mem[12'(pushed_cnt)] = v;
    pushed_cnt++;
  endtask

  // One clock cycle: sample at negedge, check against the reference, advance it.
  task automatic tick();
    @(negedge rd_clk);
    acc = 0;
    rd  = read_en;
    n_checks++;
    if (read_en && fifo_empty) begin
      n_fail++;
      $display("FAIL read_into_empty: read_en=%0b fifo_empty=%0b", read_en, fifo_empty);
    end
    if (reset) begin
      m_wc = '0; m_on = 0; m_have_prev = 0; m_err = 0; m_eidx = '0; held = 0;
      exp_idx = popped_cnt;
    end else begin
      n_checks++;
      if (word_count !== m_wc) begin
        n_fail++;
        $display("FAIL word_count: got %0d expected %0d", word_count, m_wc);
      end
      n_checks++;
      if (seq_error !== m_err || err_index !== m_eidx) begin
        n_fail++;
        $display("FAIL seq_flags: got err=%0b idx=%0d expected err=%0b idx=%0d",
                 seq_error, err_index, m_err, m_eidx);
      end
      if (held) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== held_data) begin
          n_fail++;
          $display("FAIL hold: got valid=%0b data=%0h expected valid=1 data=%0h",
                   m_valid, m_data, held_data);
        end
      end
      held      = (m_valid === 1'b1) && !m_ready;
      held_data = m_data;
      if (m_valid && m_ready) begin
        acc      = 1;
        acc_data = m_data;
        n_checks++;
        if (exp_idx >= pushed_cnt || m_data !== fifo_mem[12'(exp_idx)]) begin
          n_fail++;
          $display("FAIL stream_data: got %0h expected %0h (index %0d)",
                   m_data, fifo_mem[12'(exp_idx)], exp_idx);
        end
        exp_idx++;
        if (seq_check_en && m_on) begin
          if (m_have_prev && (m_data !== 16'(m_prev + 16'd1)) && !m_err) begin
            m_err  = 1;
            m_eidx = m_wc;
          end
          m_prev      = m_data;
          m_have_prev = 1;
        end
        m_wc = m_wc + 32'd1;
      end
      if (!seq_check_en) begin
        m_on = 0;
        m_have_prev = 0;
      end else if (!m_on) begin
        m_on = 1;
      end
    end
    @(posedge rd_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    push_word(16'h1234);
    reset = 1'b1;
    m_ready = 1'b1;
    tick();
    tick();
    n_checks++; if (read_en !== 1'b0) begin n_fail++; $display("FAIL rst_read_en: got %0b expected 0", read_en); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %0b expected 0", m_valid); end
    n_checks++; if (m_data !== 16'h0) begin n_fail++; $display("FAIL rst_m_data: got %0h expected 0", m_data); end
    n_checks++; if (seq_error !== 1'b0) begin n_fail++; $display("FAIL rst_seq_error: got %0b expected 0", seq_error); end
    n_checks++; if (err_index !== 32'd0) begin n_fail++; $display("FAIL rst_err_index: got %0d expected 0", err_index); end
    n_checks++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL rst_word_count: got %0d expected 0", word_count); end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (word_count !== 32'd1) begin n_fail++; $display("FAIL rst_first_word: got %0d expected 1", word_count); end
  endtask

  task automatic test_empty();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (read_en !== 1'b0) begin n_fail++; $display("FAIL empty_read_en: got %0b expected 0", read_en); end
      n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL empty_m_valid: got %0b expected 0", m_valid); end
    end
    n_checks++; if (word_count !== 32'd0) begin n_fail++; $display("FAIL empty_word_count: got %0d expected 0", word_count); end
  endtask

  task automatic test_fill_drain();
    int n_rd = 0, last_rd = -1, n_acc = 0, first_acc = -1, last_acc = -1;
    do_reset();
    for (int i = 0; i < 512; i++) push_word(16'(i));
    m_ready = 1'b1;
    seq_check_en = 1'b1;
    for (int c = 0; c < 520; c++) begin
      tick();
      if (rd) begin n_rd++; last_rd = c; end
      if (acc) begin
        n_acc++;
        if (first_acc < 0) first_acc = c;
        last_acc = c;
      end
    end
    n_checks++; if (n_rd != 512 || last_rd != 511) begin n_fail++; $display("FAIL fill_reads: got %0d last %0d expected 512 last 511", n_rd, last_rd); end
    n_checks++; if (first_acc != 2) begin n_fail++; $display("FAIL fill_latency: got cycle %0d expected 2", first_acc); end
    n_checks++; if (n_acc != 512 || last_acc != 513) begin n_fail++; $display("FAIL fill_throughput: got %0d last %0d expected 512 last 513", n_acc, last_acc); end
    n_checks++; if (word_count !== 32'd512) begin n_fail++; $display("FAIL fill_word_count: got %0d expected 512", word_count); end
    n_checks++; if (seq_error !== 1'b0) begin n_fail++; $display("FAIL fill_seq_error: got %0b expected 0", seq_error); end
    seq_check_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int n_rd = 0, n_acc = 0;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(16'(i));
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rd) n_rd++;
    end
    n_checks++; if (n_rd != 4) begin n_fail++; $display("FAIL bp_reads: got %0d expected 4", n_rd); end
    n_checks++; if (m_valid !== 1'b1 || m_data !== 16'd0) begin n_fail++; $display("FAIL bp_hold: got valid=%0b data=%0h expected valid=1 data=0", m_valid, m_data); end
    m_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (acc) n_acc++;
    end
    n_checks++; if (n_acc != 8 || word_count !== 32'd8) begin n_fail++; $display("FAIL bp_drain: got %0d words count %0d expected 8", n_acc, word_count); end
  endtask

  task automatic test_seq_error();
    logic [DATA_LEN-1:0] words [6];
    int n_acc = 0;
    words[0] = 16'd0; words[1] = 16'd1; words[2] = 16'd2;
    words[3] = 16'd3; words[4] = 16'hDEAD; words[5] = 16'd5;
    do_reset();
    seq_check_en = 1'b1;
    for (int i = 0; i < 6; i++) push_word(words[i]);
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (acc) begin
        n_acc++;
        if (n_acc == 4) begin
          n_checks++; if (seq_error !== 1'b0) begin n_fail++; $display("FAIL seq_before: got %0b expected 0", seq_error); end
        end
        if (n_acc == 5) begin
          n_checks++; if (seq_error !== 1'b1 || err_index !== 32'd4) begin n_fail++; $display("FAIL seq_detect: got err=%0b idx=%0d expected err=1 idx=4", seq_error, err_index); end
        end
      end
    end
    n_checks++; if (seq_error !== 1'b1 || err_index !== 32'd4) begin n_fail++; $display("FAIL seq_sticky: got err=%0b idx=%0d expected err=1 idx=4", seq_error, err_index); end
    n_checks++; if (word_count !== 32'd6) begin n_fail++; $display("FAIL seq_word_count: got %0d expected 6", word_count); end
    seq_check_en = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    seq_check_en = 1'b1;
    push_word(16'hFFFE); push_word(16'hFFFF); push_word(16'h0000); push_word(16'h0001);
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    n_checks++; if (seq_error !== 1'b0 || word_count !== 32'd4) begin n_fail++; $display("FAIL wrap: got err=%0b count=%0d expected err=0 count=4", seq_error, word_count); end
    seq_check_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    int n_acc = 0;
    logic [DATA_LEN-1:0] first_word = '0;
    do_reset();
    for (int i = 0; i < 12; i++) push_word(16'(100 + i));
    m_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    m_ready = 1'b0;
    tick();
    tick();
    do_reset();
    n_checks++; if (m_valid !== 1'b0 || word_count !== 32'd0) begin n_fail++; $display("FAIL midrst_clear: got valid=%0b count=%0d expected valid=0 count=0", m_valid, word_count); end
    m_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (acc) begin
        if (n_acc == 0) first_word = acc_data;
        n_acc++;
      end
    end
    n_checks++; if (first_word !== 16'd107) begin n_fail++; $display("FAIL midrst_resume: got %0d expected 107", first_word); end
    n_checks++; if (n_acc != 5 || word_count !== 32'd5) begin n_fail++; $display("FAIL midrst_count: got %0d count %0d expected 5", n_acc, word_count); end
  endtask

  task automatic test_random();
    logic [DATA_LEN-1:0] next_val = 16'hFFF0;
    do_reset();
    seq_check_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 6 && pushed_cnt < FIFO_SIZE - 1) begin
        if ($urandom_range(0, 19) == 0) push_word(16'($urandom));
        else push_word(next_val);
        next_val = next_val + 16'd1;
      end
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) seq_check_en = ~seq_check_en;
      reset = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 40; c++) tick();
    n_checks++; if (!fifo_empty || exp_idx != pushed_cnt) begin n_fail++; $display("FAIL rand_drain: got delivered %0d of %0d expected all", exp_idx, pushed_cnt); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rand_idle: got valid=%0b expected 0", m_valid); end
  endtask

  initial begin
    reset = 1'b1;
    m_ready = 1'b0;
    seq_check_en = 1'b0;
    test_reset();
    test_empty();
    test_fill_drain();
    test_backpressure();
    test_seq_error();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
